sequence_controller: RTL and testbench
======================================

Name: sequence_controller

Overview:
- Control sequencer for the VeriRISC CPU. It steps every instruction through 8 fixed phases and decodes the current opcode into the datapath strobes.
- Its data_e output directly drives the enable of the accumulator-to-data-bus tri-state driver. It also drives the address mux select, memory rd/wr, instruction register load, PC increment/load, and accumulator load.
- Contains the phase counter and the halt latch, so it is the only sequential control block in the core.

Parameters:
- OPC_W, 3, opcode width.
- PHASE_W, 3, phase counter width (8 phases).

Ports:
- clk     input   1        system clock, all state updates on rising edge
- rst     input   1        synchronous, active-high reset
- opcode  input   OPC_W    opcode from instruction register; valid from phase 3 onward
- zero    input   1        accumulator-is-zero flag
- phase   output  PHASE_W  current phase, for observation and debug
- sel     output  1        address mux: 1=PC, 0=IR operand
- rd      output  1        memory read
- ld_ir   output  1        load instruction register
- inc_pc  output  1        increment PC
- ld_pc   output  1        load PC from IR operand
- ld_ac   output  1        load accumulator from ALU
- wr      output  1        memory write
- data_e  output  1        enable for accumulator data-bus driver
- halt    output  1        CPU halted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. rst sampled high at a clk edge sets phase=0 and clears the halt latch. rst has priority over every other event, including mid-instruction and while halted.
- Phase encoding: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Phase counter: when not halted, phase increments by 1 every clock and wraps 7->0 with no idle cycle between instructions.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Output decode: outputs are combinational from the registered phase, the halt latch, opcode and zero (zero latency relative to phase). Any output not listed for a phase is 0.
  - phase 0: sel=1
  - phase 1: sel=1, rd=1
  - phase 2: sel=1, rd=1, ld_ir=1
  - phase 3: sel=1, rd=1, ld_ir=1
  - phase 4: inc_pc=1; halt=1 if opcode==HLT
  - phase 5: rd=ALUOP
  - phase 6: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO
  - phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO
- Reset state: phase=0, so the outputs are sel=1 and every other output 0, including halt.
- Bus ordering: for STO, data_e rises one cycle before wr and stays high through the wr cycle, so the bus is stable before and during the write.
- Halt:
  - At the clock edge that ends phase 4 with opcode==HLT, the halt latch sets.
  - While latched: phase holds at 4, halt=1, and all other outputs are 0 (the inc_pc of phase 4 is suppressed once latched).
  - The halt latch is cleared only by rst.
- Opcode and zero changes: the decode uses the opcode value present each cycle. The IR is stable in phases 3-7, so no internal opcode capture is required. zero is sampled only in phase 6.
- Invariant: ld_pc and inc_pc are never both 1 in the same cycle.

Decomposition:
- Package veririsc_pkg holds:
  - opcode localparams: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
  - phase localparams: INST_ADDR .. STORE
  - OPC_W and PHASE_W widths
- One natural sub-module: phase_counter. It is a 3-bit wrapping counter with synchronous reset and a hold input, driven by the halt latch.
- Decode stays in sequence_controller.

Test Plan:
1. rst=1 for 2 cycles, then released -> phase=0, sel=1, all other outputs 0. Phase then steps 1..7 and wraps to 0 on the 8th clock.
2. opcode=LDA (5), full instruction ->
   - rd=1 in phases 1,2,3,5,6,7
   - ld_ir=1 in phases 2-3
   - inc_pc=1 in phase 4 only
   - ld_ac=1 in phase 7 only
   - wr=0 and data_e=0 throughout
3. opcode=STO (6) -> data_e=1 in phases 6 and 7, wr=1 in phase 7 only, rd=0 in phases 5-7, ld_ac=0 throughout.
4. opcode=SKZ (1):
   - zero=1 -> inc_pc=1 in phases 4 and 6
   - zero=0 -> inc_pc=1 in phase 4 only
   - opcode=JMP (7) -> ld_pc=1 in phases 6-7, inc_pc=1 in phase 4 only
5. opcode=HLT (0):
   - phase 4 shows halt=1 with inc_pc=1
   - afterwards phase stays 4, halt=1, all other outputs 0 for 10+ cycles
   - rst=1 for one cycle -> phase=0, halt=0
6. Reset mid-instruction: opcode=STO, assert rst during phase 6 -> next cycle phase=0, data_e=0, wr never asserted.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared widths, opcode values and phase encodings for the VeriRISC control path.
package veririsc_pkg;

    localparam int OPC_W   = 3;
    localparam int PHASE_W = 3;

    localparam logic [OPC_W-1:0] HLT = 3'd0;
    localparam logic [OPC_W-1:0] SKZ = 3'd1;
    localparam logic [OPC_W-1:0] ADD = 3'd2;
    localparam logic [OPC_W-1:0] AND = 3'd3;
    localparam logic [OPC_W-1:0] XOR = 3'd4;
    localparam logic [OPC_W-1:0] LDA = 3'd5;
    localparam logic [OPC_W-1:0] STO = 3'd6;
    localparam logic [OPC_W-1:0] JMP = 3'd7;

    localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] STORE      = 3'd7;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        return (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping instruction-phase counter with synchronous reset and a hold input.
module phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequence_controller.sv
// VeriRISC control sequencer: steps each instruction through eight phases and
// decodes phase/opcode/zero into the datapath strobes; owns the halt latch.
module sequence_controller
    import veririsc_pkg::*;
#(
    parameter int OPC_W   = veririsc_pkg::OPC_W,
    parameter int PHASE_W = veririsc_pkg::PHASE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic [PHASE_W-1:0] phase,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt
);

    logic halt_q;
    logic halt_next;
    logic halt_now;
    logic hold;
    logic alu_op;

    // Hold is also raised on the edge that sets the latch so phase parks at 4.
    phase_counter #(
        .WIDTH (PHASE_W)
    ) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .count (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_next;
        end
    end

    always_comb begin
        halt_now  = (phase == OP_ADDR) && (opcode == HLT);
        halt_next = halt_q || halt_now;
        hold      = halt_next;
    end

    always_comb begin
        alu_op = is_alu_op(opcode);
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = halt_q || halt_now;
        if (!halt_q) begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                    wr     = (opcode == STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_controller.sv
// Directed table-driven bench for sequence_controller plus halt and mid-instruction reset sequences.
module tb_sequence_controller;

    // Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    typedef struct {
        logic       rst;
        logic [2:0] opcode;
        logic       zero;
        logic [2:0] exp_phase;
        logic [8:0] exp_out;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int checks;
    int errors;
    vec_t vecs[$];

    sequence_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [2:0] opc, input logic z,
                          input logic [2:0] ph, input logic [8:0] outs);
        vec_t v;
        v.rst = r;
        v.opcode = opc;
        v.zero = z;
        v.exp_phase = ph;
        v.exp_out = outs;
        vecs.push_back(v);
    endtask

    // Phases 0-4 are identical for every non-HLT opcode.
    task automatic addFetch(input logic [2:0] opc, input logic z);
        addVec(1'b0, opc, z, 3'd0, 9'b100000000);
        addVec(1'b0, opc, z, 3'd1, 9'b110000000);
        addVec(1'b0, opc, z, 3'd2, 9'b111000000);
        addVec(1'b0, opc, z, 3'd3, 9'b111000000);
        addVec(1'b0, opc, z, 3'd4, 9'b000100000);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        opcode = v.opcode;
        zero   = v.zero;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [8:0] act;
        act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        checks++;
        if (phase !== v.exp_phase) begin
            errors++;
            $display("[TB] FAIL %s phase: got %0d expected %0d", name, phase, v.exp_phase);
        end
        checks++;
        if (act !== v.exp_out) begin
            errors++;
            $display("[TB] FAIL %s outputs {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}: got %b expected %b",
                     name, act, v.exp_out);
        end
        checks++;
        if (ld_pc && inc_pc) begin
            errors++;
            $display("[TB] FAIL %s pc_exclusive: got ld_pc=1 inc_pc=1 expected not both", name);
        end
    endtask

    // Drive shortly after a rising edge, sample mid-cycle, then advance one clock.
    task automatic runStep(input vec_t v, input string name);
        applyStimulus(v);
        #3;
        checkOutput(v, name);
        @(posedge clk);
        #1;
    endtask

    task automatic runOne(input logic r, input logic [2:0] opc, input logic z,
                          input logic [2:0] ph, input logic [8:0] outs, input string name);
        vec_t v;
        v.rst = r;
        v.opcode = opc;
        v.zero = z;
        v.exp_phase = ph;
        v.exp_out = outs;
        runStep(v, name);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;

        // LDA
        addFetch(3'd5, 1'b0);
        addVec(1'b0, 3'd5, 1'b0, 3'd5, 9'b010000000);
        addVec(1'b0, 3'd5, 1'b0, 3'd6, 9'b010000000);
        addVec(1'b0, 3'd5, 1'b0, 3'd7, 9'b010001000);
        // STO
        addFetch(3'd6, 1'b0);
        addVec(1'b0, 3'd6, 1'b0, 3'd5, 9'b000000000);
        addVec(1'b0, 3'd6, 1'b0, 3'd6, 9'b000000010);
        addVec(1'b0, 3'd6, 1'b0, 3'd7, 9'b000000110);
        // SKZ with zero=1
        addFetch(3'd1, 1'b1);
        addVec(1'b0, 3'd1, 1'b1, 3'd5, 9'b000000000);
        addVec(1'b0, 3'd1, 1'b1, 3'd6, 9'b000100000);
        addVec(1'b0, 3'd1, 1'b1, 3'd7, 9'b000000000);
        // SKZ with zero=0
        addFetch(3'd1, 1'b0);
        addVec(1'b0, 3'd1, 1'b0, 3'd5, 9'b000000000);
        addVec(1'b0, 3'd1, 1'b0, 3'd6, 9'b000000000);
        addVec(1'b0, 3'd1, 1'b0, 3'd7, 9'b000000000);
        // JMP, zero=1 must not produce inc_pc in phase 6
        addFetch(3'd7, 1'b1);
        addVec(1'b0, 3'd7, 1'b1, 3'd5, 9'b000000000);
        addVec(1'b0, 3'd7, 1'b1, 3'd6, 9'b000010000);
        addVec(1'b0, 3'd7, 1'b1, 3'd7, 9'b000010000);
        // ADD
        addFetch(3'd2, 1'b0);
        addVec(1'b0, 3'd2, 1'b0, 3'd5, 9'b010000000);
        addVec(1'b0, 3'd2, 1'b0, 3'd6, 9'b010000000);
        addVec(1'b0, 3'd2, 1'b0, 3'd7, 9'b010001000);

        repeat (2) @(posedge clk);
        #1;
        runOne(1'b1, 3'd0, 1'b0, 3'd0, 9'b100000000, "reset_state");

        foreach (vecs[i]) begin
            runStep(vecs[i], $sformatf("vec%0d", i));
        end

        // Halt: fetch HLT, latch at the end of phase 4, then hold with all strobes off.
        runOne(1'b0, 3'd0, 1'b0, 3'd0, 9'b100000000, "hlt_p0");
        runOne(1'b0, 3'd0, 1'b0, 3'd1, 9'b110000000, "hlt_p1");
        runOne(1'b0, 3'd0, 1'b0, 3'd2, 9'b111000000, "hlt_p2");
        runOne(1'b0, 3'd0, 1'b0, 3'd3, 9'b111000000, "hlt_p3");
        runOne(1'b0, 3'd0, 1'b0, 3'd4, 9'b000100001, "hlt_p4");
        for (int k = 0; k < 12; k++) begin
            runOne(1'b0, (k < 6) ? 3'd0 : 3'd6, k[0], 3'd4, 9'b000000001,
                   $sformatf("halted%0d", k));
        end
        runOne(1'b1, 3'd6, 1'b0, 3'd4, 9'b000000001, "halted_rst");
        runOne(1'b0, 3'd6, 1'b0, 3'd0, 9'b100000000, "after_halt_rst");

        // Mid-instruction reset during STO phase 6 aborts before the write.
        runOne(1'b0, 3'd6, 1'b0, 3'd1, 9'b110000000, "mid_p1");
        runOne(1'b0, 3'd6, 1'b0, 3'd2, 9'b111000000, "mid_p2");
        runOne(1'b0, 3'd6, 1'b0, 3'd3, 9'b111000000, "mid_p3");
        runOne(1'b0, 3'd6, 1'b0, 3'd4, 9'b000100000, "mid_p4");
        runOne(1'b0, 3'd6, 1'b0, 3'd5, 9'b000000000, "mid_p5");
        runOne(1'b1, 3'd6, 1'b0, 3'd6, 9'b000000010, "mid_p6_rst");
        runOne(1'b0, 3'd6, 1'b0, 3'd0, 9'b100000000, "mid_after_p0");
        runOne(1'b0, 3'd6, 1'b0, 3'd1, 9'b110000000, "mid_after_p1");
        runOne(1'b0, 3'd6, 1'b0, 3'd2, 9'b111000000, "mid_after_p2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
